// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - opcodes, state encoding and field widths shared by the SPI flash responder
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int SPI_ADDR_BITS  = 24;
    localparam int SPI_DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - two-flop synchronizer for one SPI pin with rise/fall detection on the synchronized value
module spi_pin_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 READ responder streaming ROM bytes; SPI_FLASH_FAST_READ_EN adds 0Bh with dummy byte
module spi_flash_responder #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic              cmd_err
);
    import spi_flash_pkg::*;

    spi_state_e  state;
    spi_state_e  state_nxt;

    logic        cs_s;
    logic        cs_rise;
    logic        cs_fall_unused;
    logic        sclk_s_unused;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_s;
    logic        mosi_rise_unused;
    logic        mosi_fall_unused;

    logic [4:0]  bit_cnt;
    logic [22:0] shift_in;
    logic [23:0] addr_q;
    logic [7:0]  data_sh;
    logic [7:0]  hold;
    logic [2:0]  out_cnt;
    logic        started;
    logic        rd_d1;
    logic        dest_shift;
`ifdef SPI_FLASH_FAST_READ_EN
    logic        fast_q;
    logic        dummy_done;
`endif

    logic [7:0]  cmd_byte;
    logic [23:0] addr_new;
    logic [23:0] addr_inc;
    logic [23:0] fetch_addr;
    logic        leave;
    logic        cmd_done;
    logic        cmd_ok;
    logic        addr_done;
    logic        first_fetch;
    logic        enter_ignore;

    spi_pin_sync u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (spi_cs),
        .sync    (cs_s),
        .rise    (cs_rise),
        .fall    (cs_fall_unused)
    );

    spi_pin_sync u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (spi_sclk),
        .sync    (sclk_s_unused),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_pin_sync u_mosi_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (spi_mosi),
        .sync    (mosi_s),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    // Shift register excludes the incoming bit, so opcode and address are complete in the same cycle as their last edge.
    assign cmd_byte     = {shift_in[6:0], mosi_s};
    assign addr_new     = {shift_in, mosi_s};
    assign addr_inc     = addr_q + 24'd1;
    assign leave        = (state != ST_IDLE) && !cs_s;
    assign cmd_done     = (state == ST_CMD) && sclk_rise && (bit_cnt == 5'd7);
    assign addr_done    = (state == ST_ADDR) && sclk_rise && (bit_cnt == 5'(SPI_ADDR_BITS - 1));
    assign enter_ignore = !leave && cmd_done && !cmd_ok;

`ifdef SPI_FLASH_FAST_READ_EN
    assign dummy_done  = (state == ST_DUMMY) && sclk_rise && (bit_cnt == 5'(SPI_DUMMY_BITS - 1));
    assign cmd_ok      = (cmd_byte == CMD_READ) || (cmd_byte == CMD_FAST_READ);
    assign first_fetch = !leave && ((addr_done && !fast_q) || dummy_done);
    assign fetch_addr  = dummy_done ? addr_q : addr_new;
`else
    assign cmd_ok      = (cmd_byte == CMD_READ);
    assign first_fetch = !leave && addr_done;
    assign fetch_addr  = addr_new;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cs_rise) state_nxt = ST_CMD;
            ST_CMD:    if (cmd_done) state_nxt = cmd_ok ? ST_ADDR : ST_IGNORE;
`ifdef SPI_FLASH_FAST_READ_EN
            ST_ADDR:   if (addr_done) state_nxt = fast_q ? ST_DUMMY : ST_DATA;
            ST_DUMMY:  if (dummy_done) state_nxt = ST_DATA;
`else
            ST_ADDR:   if (addr_done) state_nxt = ST_DATA;
`endif
            ST_DATA:   state_nxt = ST_DATA;
            ST_IGNORE: state_nxt = ST_IGNORE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (leave) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rom_rd      <= 1'b0;
            rom_addr    <= '0;
            cmd_err     <= 1'b0;
            bit_cnt     <= '0;
            shift_in    <= '0;
            addr_q      <= '0;
            data_sh     <= '0;
            hold        <= '0;
            out_cnt     <= '0;
            started     <= 1'b0;
            rd_d1       <= 1'b0;
            dest_shift  <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            rom_rd  <= 1'b0;
            cmd_err <= enter_ignore;
            rd_d1   <= rom_rd;
            if (leave) begin
                // Dropping the returned byte of an in-flight read is what discards the prefetch.
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                rd_d1       <= 1'b0;
                dest_shift  <= 1'b0;
                bit_cnt     <= '0;
                out_cnt     <= '0;
                started     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_rise) bit_cnt <= '0;
                    end
                    ST_CMD, ST_ADDR: begin
                        if (sclk_rise) begin
                            shift_in <= {shift_in[21:0], mosi_s};
                            bit_cnt  <= (cmd_done || addr_done) ? 5'd0 : bit_cnt + 5'd1;
                        end
                    end
`ifdef SPI_FLASH_FAST_READ_EN
                    ST_DUMMY: begin
                        if (sclk_rise) bit_cnt <= dummy_done ? 5'd0 : bit_cnt + 5'd1;
                    end
`endif
                    ST_DATA: begin
                        if (rd_d1) begin
                            if (dest_shift) begin
                                data_sh    <= rom_data;
                                out_cnt    <= '0;
                                started    <= 1'b0;
                                dest_shift <= 1'b0;
                                rom_rd     <= 1'b1;
                                addr_q     <= addr_inc;
                                rom_addr   <= addr_inc[ADDR_W-1:0];
                            end else begin
                                hold <= rom_data;
                            end
                        end
                        if (sclk_fall) begin
                            out_cnt <= out_cnt + 3'd1;
                            started <= 1'b1;
                            // Byte boundary: the prefetched byte supplies bit 7 on this same edge.
                            if (started && (out_cnt == 3'd0)) begin
                                spi_miso <= hold[7];
                                data_sh  <= {hold[6:0], 1'b0};
                                rom_rd   <= 1'b1;
                                addr_q   <= addr_inc;
                                rom_addr <= addr_inc[ADDR_W-1:0];
                            end else begin
                                spi_miso <= data_sh[7];
                                data_sh  <= {data_sh[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
`ifdef SPI_FLASH_FAST_READ_EN
                if (cmd_done) fast_q <= (cmd_byte == CMD_FAST_READ);
`endif
                if (addr_done) addr_q <= addr_new;
                if (first_fetch) begin
                    rom_rd      <= 1'b1;
                    rom_addr    <= fetch_addr[ADDR_W-1:0];
                    addr_q      <= fetch_addr;
                    spi_miso_oe <= 1'b1;
                    dest_shift  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI mode-0 flash responder: the device end of the READ (03h) transaction our VGA ROM streamer issues. Sits in the top level or testbench in place of an external flash chip. Decodes command and 24-bit address from MOSI, then streams bytes from a synchronous ROM read port on MISO until chip select drops. Runs entirely on the responder's own system clock, oversampling the SPI pins.

## Interface
- `ADDR_W`, 24: ROM read-port address width; the low `ADDR_W` bits of the 24-bit SPI address are used.
- `clk` in 1: system clock; at least 8× the SCLK frequency.
- `reset_n` in 1: asynchronous, active-low reset.
- `spi_cs` in 1: chip select, **active HIGH** (matches our master's convention).
- `spi_sclk` in 1: SPI clock, asynchronous to `clk`, idle low.
- `spi_mosi` in 1: command/address bits, MSB first.
- `spi_miso` out 1: data bits, MSB first.
- `spi_miso_oe` out 1: MISO output enable; pad tristates when low.
- `rom_rd` out 1: one-cycle read strobe.
- `rom_addr` out `ADDR_W`: ROM byte address, valid with `rom_rd`.
- `rom_data` in 8: ROM byte, valid exactly one `clk` after `rom_rd`.
- `busy` out 1: high in any state other than IDLE.
- `cmd_err` out 1: one-cycle pulse when an unsupported opcode completes.

## Operation
- `spi_cs`, `spi_sclk`, `spi_mosi` each pass through a 2-flop synchronizer. Rising/falling SCLK edges are detected from the synchronized value.
- States: IDLE, CMD, ADDR, DUMMY (only with `FAST_READ_EN`), DATA, IGNORE.
- IDLE: on synchronized `spi_cs` 0→1 → CMD, bit counter = 0.
- CMD: shift MOSI on each rising edge. After the 8th bit:
  - 03h → ADDR.
  - 0Bh with `FAST_READ_EN` → ADDR.
  - Otherwise → IGNORE and pulse `cmd_err`.
- ADDR: shift 24 bits. On the 24th rising edge:
  - For READ: assert `rom_rd` with `rom_addr` = addr[ADDR_W-1:0], load the returned byte into the shift register, set `spi_miso_oe` = 1, go to DATA.
  - For FAST_READ: go to DUMMY.
- DUMMY: count 8 rising edges, then perform the same fetch/load → DATA.
- DATA:
  - On each falling edge, shift the next bit onto `spi_miso`. Bit 7 of the first byte is presented at the first falling edge after the load.
  - Immediately after a byte is loaded, the address increments and the next byte is prefetched into a holding register.
  - On the falling edge after bit 0, the holding register moves into the shift register and the next prefetch is issued.
- Address increment wraps modulo 2^24; `rom_addr` therefore wraps at 2^ADDR_W.
- IGNORE: `spi_miso_oe` = 0; ignore SCLK until CS drops.
- CS dropping in any state returns to IDLE next cycle. On that transition: `spi_miso_oe` = 0, `spi_miso` = 0, and any outstanding prefetch is discarded.
- A CS edge and an SCLK edge in the same cycle: the CS edge wins.
- An SCLK edge while CS is low: ignored.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `rom_rd`=0, `rom_addr`=0, `busy`=0, `cmd_err`=0, state IDLE, all shift/counter registers 0.
- Pin-to-action latency: 3 `clk` (2 sync + 1 register). MISO changes within 4 `clk` of the SCLK falling edge at the pin.
- First byte: `rom_rd` fires 1 `clk` after the last address (or dummy) rising edge is detected; the byte is loaded 2 `clk` after that. This is within the ≥4-clk half-period guaranteed by the clock-ratio rule.
- `rom_rd` never asserts in two consecutive cycles. `rom_data` is sampled only in the cycle after `rom_rd`.
- `cmd_err` pulses for exactly 1 `clk`, in the cycle the FSM enters IGNORE.

## Configuration
- `SPI_FLASH_FAST_READ_EN` defined: opcode 0Bh is accepted and followed by 8 dummy clocks before data.
- Undefined: the DUMMY state is not built, and 0Bh is treated as unsupported (IGNORE + `cmd_err`).

## Structure
- Shared package `spi_flash_pkg` holds:
  - Opcode constants `CMD_READ`=8'h03, `CMD_FAST_READ`=8'h0B.
  - The state encoding.
  - `SPI_ADDR_BITS`=24.
  - `SPI_DUMMY_BITS`=8.
- Sub-module `spi_pin_sync` holds the 2-flop synchronizer plus rise/fall detect; instantiate it for SCLK and CS, and reuse it (without the edge outputs) for MOSI.

## Test plan
- READ at 000040h, SCLK = clk/8, ROM[i]=i: MISO yields 40h, 41h, 42h, 43h MSB-first, with bit 7 of 40h valid before the rising edge after address bit 0.
- READ at FFFFFEh, `ADDR_W`=24, 4 bytes: `rom_addr` sequence FFFFFE, FFFFFF, 000000, 000001.
- Opcode 9Fh: `cmd_err` pulses once, `spi_miso_oe` stays 0 for the rest of the CS window, and the next READ works normally.
- CS dropped after bit 3 of the 2nd data byte: `spi_miso_oe`=0 and `busy`=0 within 4 `clk`, and the next transaction restarts at CMD.
- `reset_n` pulsed low mid-DATA: all outputs at reset values immediately (asynchronously), with no `rom_rd` until a new CS rise.
- With `SPI_FLASH_FAST_READ_EN`: 0Bh, address 000010h, 8 dummy clocks → MISO yields 10h, 11h. Without the macro, the same stimulus produces a `cmd_err` pulse.
